// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial transmit path (arbiter and serial_protocol).
// No logic here; latency and backpressure live with the users of these types.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_START,
    ST_WAIT_END
  } tx_state_t;

  localparam int SERIAL_DATA_W  = 8;
  localparam int SERIAL_TIMEOUT = 32;

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after index last, wrapping.
// Zero latency; no backpressure, the caller decides when to act on valid.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from farthest to nearest so the candidate closest after last wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int s = NUM_REQ; s >= 1; s--) begin
      if (req[IDX_W'((int'(last) + s) % NUM_REQ)]) begin
        valid = 1'b1;
        idx   = IDX_W'((int'(last) + s) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding one serial_protocol transmitter; grant one cycle after req seen in IDLE.
// Requesters hold req until granted; a frame stalls at most TIMEOUT cycles per wait state.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SERIAL_DATA_W,
  parameter int TIMEOUT = SERIAL_TIMEOUT
) (
  input  logic                      sys_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      timeout_err,
  output logic                      busy,
  output logic                      tx_send,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_strobe
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  tx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 send_q, send_d;
  logic [DATA_W-1:0]    data_q, data_d;

  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_SEND;
          grant_d = NUM_REQ'(1) << pick_idx;
          data_d  = req_data[pick_idx*DATA_W +: DATA_W];
          last_d  = pick_idx;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_strobe) begin
          state_d = ST_WAIT_END;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_END: begin
        if (!tx_strobe) begin
          done_d  = NUM_REQ'(1) << last_q;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // Every state starts with a fresh count, so the counter can never wrap.
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
    send_d = (state_d == ST_SEND);
  end

  always_ff @(posedge sys_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      send_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      send_q  <= send_d;
      data_q  <= data_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign busy        = busy_q;
  assign tx_send     = send_q;
  assign tx_data     = data_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Randomised bench for serial_tx_arbiter against a frame-level timing model.
// Each frame's strobe profile (rise offset, high length) is predicted arithmetically.
module tb_serial_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 32;

  logic           sys_clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           timeout_err;
  logic           busy;
  logic           tx_send;
  logic [W-1:0]   tx_data;
  logic           tx_strobe;

  always #5 sys_clk = ~sys_clk;

  serial_tx_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .TIMEOUT (T)
  ) dut (
    .sys_clk     (sys_clk),
    .i_rst       (i_rst),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_strobe   (tx_strobe)
  );

  int n_checks = 0;
  int n_errors = 0;

  // frame-level model
  int       cyc = 0;
  bit       in_frame = 0;
  int       send_cyc, end_cyc;
  bit       end_done;
  int       last_m = N - 1;
  int       pr, ph;
  logic [N-1:0] e_grant = '0, e_done = '0;
  logic         e_err = 0, e_busy = 0, e_send = 0;
  logic [W-1:0] e_data = '0;

  // stimulus controls
  logic [N-1:0]   req_v = '0;
  logic [N*W-1:0] data_v = '0;
  bit rand_mode = 0;
  bit auto_drop = 1;
  int dir_r = 2, dir_h = 10;

  // observation log
  int gnt_q[$];
  int send_at = -1, err_at = -1, gnt_at = -1;
  int n_send = 0, n_gnt = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int s = 1; s <= N; s++) begin
      if (r[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  // Cycles from SEND to IDLE re-entry for strobe high on offsets [r, r+h).
  function automatic int frame_len(input int r, input int h, output bit ok);
    int ks;
    ks = (r < 1) ? 1 : r;
    if (ks <= T && ks < r + h) begin
      if (r + h <= ks + T) begin
        ok = 1;
        return r + h + 1;
      end
      ok = 0;
      return ks + T + 1;
    end
    ok = 0;
    return T + 1;
  endfunction

  task automatic choose_profile();
    int ks;
    if (!rand_mode) begin
      pr = dir_r;
      ph = dir_h;
      return;
    end
    case ($urandom_range(0, 5))
      0, 1, 2: begin pr = $urandom_range(0, 6);         ph = $urandom_range(1, 8); end
      3:       begin pr = $urandom_range(T - 2, T + 1); ph = $urandom_range(1, 4); end
      4: begin
        pr = $urandom_range(0, 4);
        ks = (pr < 1) ? 1 : pr;
        ph = ks - pr + $urandom_range(T - 1, T + 1);
      end
      default: begin
        if ($urandom_range(0, 1) == 0) begin pr = $urandom_range(0, 3); ph = 1000; end
        else begin pr = 1000; ph = 1; end
      end
    endcase
  endtask

  task automatic tick(input bit rst_in);
    int w, k, len;
    bit ok;
    i_rst    = rst_in;
    req      = req_v;
    req_data = data_v;
    if (in_frame) begin
      k = cyc - send_cyc;
      tx_strobe = (k >= pr) && (k < pr + ph);
    end else begin
      tx_strobe = 1'b0;
    end

    if (rst_in) begin
      in_frame = 0;
      last_m   = N - 1;
      e_grant = '0; e_done = '0; e_err = 0; e_busy = 0; e_send = 0; e_data = '0;
    end else if (!in_frame) begin
      w = rr_winner(req_v, last_m);
      e_done = '0;
      e_err  = 0;
      if (w >= 0) begin
        e_grant  = N'(1) << w;
        e_send   = 1;
        e_busy   = 1;
        e_data   = data_v[w*W +: W];
        last_m   = w;
        in_frame = 1;
        send_cyc = cyc + 1;
        choose_profile();
        len      = frame_len(pr, ph, ok);
        end_cyc  = send_cyc + len;
        end_done = ok;
        if (auto_drop && (!rand_mode || $urandom_range(0, 3) != 0)) req_v[w] = 1'b0;
      end else begin
        e_grant = '0;
        e_send  = 0;
        e_busy  = 0;
      end
    end else begin
      e_grant = '0;
      e_send  = 0;
      if (cyc + 1 == end_cyc) begin
        in_frame = 0;
        e_busy   = 0;
        e_done   = end_done ? (N'(1) << last_m) : '0;
        e_err    = !end_done;
      end else begin
        e_busy = 1;
        e_done = '0;
        e_err  = 0;
      end
    end

    @(posedge sys_clk);
    #1;
    cyc++;

    chk_val("grant", grant, e_grant);
    chk_val("done", done, e_done);
    chk_val("timeout_err", timeout_err, e_err);
    chk_val("busy", busy, e_busy);
    chk_val("tx_send", tx_send, e_send);
    chk_val("tx_data", tx_data, e_data);

    if (grant != '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) gnt_q.push_back(i);
      gnt_at = cyc;
      n_gnt++;
    end
    if (tx_send) begin
      send_at = cyc;
      n_send++;
    end
    if (timeout_err) err_at = cyc;
  endtask

  task automatic wait_grants(input string tag, input int n);
    for (int i = 0; i < 300 && gnt_q.size() < n; i++) tick(0);
    chk_val(tag, gnt_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 120; i++) begin
      tick(0);
      if (!busy) return;
    end
    chk_val(tag, busy, 1'b0);
  endtask

  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    i_rst = 1'b1; req = '0; req_data = '0; tx_strobe = 1'b0;
    data_v = {8'h0F, 8'h55, 8'hD4, 8'hFA};

    // reset and a single nominal frame from requester 0
    tick(1);
    tick(1);
    req_v = 4'b0001; auto_drop = 1; dir_r = 2; dir_h = 10;
    gnt_q.delete();
    wait_grants("first_grant", 1);
    wait_idle("first_idle");

    // all requesting: strict rotation starting from 0
    tick(1);
    req_v = 4'b1111; auto_drop = 0; dir_r = 2; dir_h = 3;
    gnt_q.delete(); n_send = 0; n_gnt = 0;
    wait_grants("rr_count", 5);
    req_v = '0;
    wait_idle("rr_idle");
    for (int i = 0; i < 5; i++) chk_val("rr_order", (i < gnt_q.size()) ? gnt_q[i] : -1, exp_ord[i]);
    chk_val("send_per_grant", n_send, n_gnt);

    // rotation skips past 2 and 3 back to 0 after serving 1
    auto_drop = 1;
    req_v = 4'b0010;
    gnt_q.delete();
    wait_grants("skip_first", 1);
    req_v = 4'b0011;
    gnt_q.delete();
    wait_grants("skip_second", 1);
    if (gnt_q.size() > 0) chk_val("rr_skip", gnt_q[0], 0);
    req_v = '0;
    wait_idle("skip_idle");

    // transmitter never starts
    dir_r = 1000; dir_h = 1;
    req_v = 4'b0110;
    err_at = -1; gnt_q.delete();
    for (int i = 0; i < 200 && err_at < 0; i++) tick(0);
    chk_val("start_to_seen", err_at >= 0, 1'b1);
    chk_val("start_to_lat", err_at - send_at, T + 1);
    for (int i = 0; i < 10 && gnt_at <= err_at; i++) tick(0);
    chk_val("start_to_regrant", gnt_at - err_at, 1);
    if (gnt_q.size() > 0) chk_val("start_to_next", gnt_q[gnt_q.size()-1], 2);
    wait_idle("start_to_idle");

    // strobe stuck high, already high during SEND
    dir_r = 0; dir_h = 1000;
    req_v = 4'b0001;
    err_at = -1;
    for (int i = 0; i < 200 && err_at < 0; i++) tick(0);
    chk_val("stuck_to_lat", err_at - send_at, T + 2);
    wait_idle("stuck_idle");

    // reset in the middle of WAIT_END
    dir_r = 2; dir_h = 20;
    req_v = 4'b1111; auto_drop = 0;
    gnt_q.delete();
    wait_grants("mid_grant", 1);
    for (int i = 0; i < 4; i++) tick(0);
    tick(1);
    chk_val("mid_rst_busy", busy, 1'b0);
    chk_val("mid_rst_data", tx_data, 8'h00);
    gnt_q.delete();
    wait_grants("mid_regrant", 1);
    if (gnt_q.size() > 0) chk_val("mid_rst_next", gnt_q[0], 0);
    req_v = '0; auto_drop = 1;
    wait_idle("mid_idle");

    // randomised traffic, data churn, strobe profiles and occasional reset
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 15) == 0) req_v[i] = 1'b1;
        else if (req_v[i] && $urandom_range(0, 63) == 0) req_v[i] = 1'b0;
        data_v[i*W +: W] = W'($urandom);
      end
      tick($urandom_range(0, 399) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
